// File: rtl/sd_cmd_tx.sv
// SD CMD-line token serialiser: start/transmission bits, index, argument, CRC7, end bit.
// Optional macro SD_CMD_NCC_EN adds an N_CC idle gap (NCC_CYCLES bit times) before done.
module sd_cmd_tx #(
    parameter int ARG_WIDTH  = 32,
    parameter int NCC_CYCLES = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clk_en,
    input  logic                 start,
    input  logic [5:0]           cmd_index,
    input  logic [ARG_WIDTH-1:0] cmd_argument,
    output logic                 cmd_out,
    output logic                 cmd_oe,
    output logic                 busy,
    output logic                 done,
    output logic [6:0]           crc7_out
);

    localparam int SR_W = ARG_WIDTH + 8;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SEND = 2'd1;
`ifdef SD_CMD_NCC_EN
    localparam logic [1:0] ST_NCC  = 2'd2;
    localparam int         NCC_W   = (NCC_CYCLES > 1) ? $clog2(NCC_CYCLES) : 1;
`endif

    if (ARG_WIDTH != 32) begin : g_bad_arg_width
        $error("sd_cmd_tx: ARG_WIDTH must be 32");
    end
    if (NCC_CYCLES < 1) begin : g_bad_ncc
        $error("sd_cmd_tx: NCC_CYCLES must be at least 1");
    end

    logic [1:0]      state_q, state_d;
    logic [SR_W-1:0] sreg_q, sreg_d;
    logic [6:0]      crc_q, crc_d;
    logic [5:0]      cnt_q, cnt_d;
    logic            done_q, done_d;
    logic [6:0]      crc7_q, crc7_d;
`ifdef SD_CMD_NCC_EN
    logic [NCC_W-1:0] ncc_q, ncc_d;
`endif

    logic       tx_bit;
    logic       crc_fb;
    logic [6:0] crc_step;

    // cnt_q counts the frame bit currently on the line (47 down to 0).
    always_comb begin
        if (cnt_q >= 6'd8) begin
            tx_bit = sreg_q[SR_W-1];
        end else if (cnt_q != 6'd0) begin
            tx_bit = crc_q[6];
        end else begin
            tx_bit = 1'b1;
        end
    end

    // Serial CRC7, polynomial x^7 + x^3 + 1.
    assign crc_fb   = sreg_q[SR_W-1] ^ crc_q[6];
    assign crc_step = {crc_q[5:0], 1'b0} ^ ({7{crc_fb}} & 7'h09);

    always_comb begin
        state_d = state_q;
        sreg_d  = sreg_q;
        crc_d   = crc_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        crc7_d  = crc7_q;
`ifdef SD_CMD_NCC_EN
        ncc_d   = ncc_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_SEND;
                    sreg_d  = {2'b01, cmd_index, cmd_argument};
                    crc_d   = 7'd0;
                    cnt_d   = 6'd47;
                end
            end
            ST_SEND: begin
                if (clk_en) begin
                    cnt_d = cnt_q - 6'd1;
                    if (cnt_q >= 6'd8) begin
                        sreg_d = {sreg_q[SR_W-2:0], 1'b0};
                        crc_d  = crc_step;
                    end else if (cnt_q != 6'd0) begin
                        // Rotate rather than shift: after seven bits the final CRC is back in place.
                        crc_d = {crc_q[5:0], crc_q[6]};
                    end else begin
                        cnt_d  = 6'd0;
                        crc7_d = crc_q;
`ifdef SD_CMD_NCC_EN
                        state_d = ST_NCC;
                        ncc_d   = NCC_W'(NCC_CYCLES - 1);
`else
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
`endif
                    end
                end
            end
`ifdef SD_CMD_NCC_EN
            ST_NCC: begin
                if (clk_en) begin
                    if (ncc_q == '0) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        ncc_d = ncc_q - 1'b1;
                    end
                end
            end
`endif
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            sreg_q  <= '0;
            crc_q   <= 7'd0;
            cnt_q   <= 6'd0;
            done_q  <= 1'b0;
            crc7_q  <= 7'd0;
`ifdef SD_CMD_NCC_EN
            ncc_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            sreg_q  <= sreg_d;
            crc_q   <= crc_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            crc7_q  <= crc7_d;
`ifdef SD_CMD_NCC_EN
            ncc_q   <= ncc_d;
`endif
        end
    end

    assign cmd_oe   = (state_q == ST_SEND);
    assign cmd_out  = (state_q == ST_SEND) ? tx_bit : 1'b1;
    assign busy     = (state_q != ST_IDLE);
    assign done     = done_q;
    assign crc7_out = crc7_q;

endmodule
